// File: rtl/imm_gen_pkg.sv
// Shared opcode constants and immediate-format encoding for the immediate
// generator queue.
package imm_gen_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_t;

endpackage

// File: rtl/imm_gen_queue_imm_decode.sv
// Combinational RV32I/RV64I immediate decoder: builds a 32-bit sign-correct
// immediate per format, then sign-extends it to XLEN.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_fmt_t        fmt
);

  logic [31:0] raw_s;

  // Opcode classification and per-format bit gathering
  always_comb begin
    fmt   = FMT_NONE;
    raw_s = 32'h0000_0000;
    case (inst[6:0])
      OP_IMM, LOAD, JALR: begin
        fmt   = FMT_I;
        raw_s = {{20{inst[31]}}, inst[31:20]};
      end
      STORE: begin
        fmt   = FMT_S;
        raw_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      BRANCH: begin
        fmt   = FMT_B;
        raw_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      LUI, AUIPC: begin
        fmt   = FMT_U;
        raw_s = {inst[31:12], 12'h000};
      end
      JAL: begin
        fmt   = FMT_J;
        raw_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: begin
        fmt   = FMT_NONE;
        raw_s = 32'h0000_0000;
      end
    endcase
  end

  // Signed cast widens U immediates to XLEN with the sign of inst[31]
  assign imm = XLEN'(signed'(raw_s));

endmodule

// File: rtl/imm_gen_queue.sv
// Immediate generator with a DEPTH-entry result FIFO and valid/ready handshakes.
// Optional macro IMM_GEN_ILLEGAL_FLAG_EN adds a per-entry out_illegal flag.
module imm_gen_queue
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
`ifdef IMM_GEN_ILLEGAL_FLAG_EN
  output logic             out_illegal,
`endif
  output logic [TAG_W-1:0] out_tag
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  dec_imm_s;
  imm_fmt_t         dec_fmt_s;
  logic             push_s;
  logic             pop_s;

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic [XLEN-1:0]  imm_mem_r [DEPTH];
  logic [2:0]       fmt_mem_r [DEPTH];
  logic [TAG_W-1:0] tag_mem_r [DEPTH];
`ifdef IMM_GEN_ILLEGAL_FLAG_EN
  logic             ill_mem_r [DEPTH];
  logic             dec_ill_s;
`endif

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst (in_inst),
    .imm  (dec_imm_s),
    .fmt  (dec_fmt_s)
  );

`ifdef IMM_GEN_ILLEGAL_FLAG_EN
  assign dec_ill_s = (dec_fmt_s == FMT_NONE) || (in_inst[1:0] != 2'b11);
`endif

  // in_ready depends only on registered occupancy, so no combinational path from out_ready
  assign in_ready  = (count_r < CNT_W'(DEPTH));
  assign out_valid = (count_r != {CNT_W{1'b0}});
  assign push_s    = in_valid && in_ready && !flush;
  assign pop_s     = out_valid && out_ready && !flush;

  // Pointer and occupancy control; flush outranks push and pop
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage, written with the decode result on each accepted push
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        imm_mem_r[i] <= {XLEN{1'b0}};
        fmt_mem_r[i] <= 3'd0;
        tag_mem_r[i] <= {TAG_W{1'b0}};
`ifdef IMM_GEN_ILLEGAL_FLAG_EN
        ill_mem_r[i] <= 1'b0;
`endif
      end
    end else if (push_s) begin
      imm_mem_r[wr_ptr_r] <= dec_imm_s;
      fmt_mem_r[wr_ptr_r] <= dec_fmt_s;
      tag_mem_r[wr_ptr_r] <= in_tag;
`ifdef IMM_GEN_ILLEGAL_FLAG_EN
      ill_mem_r[wr_ptr_r] <= dec_ill_s;
`endif
    end
  end

  // Head presentation, zeroed whenever the queue is empty
  always_comb begin
    out_imm = {XLEN{1'b0}};
    out_fmt = 3'd0;
    out_tag = {TAG_W{1'b0}};
`ifdef IMM_GEN_ILLEGAL_FLAG_EN
    out_illegal = 1'b0;
`endif
    if (out_valid) begin
      out_imm = imm_mem_r[rd_ptr_r];
      out_fmt = fmt_mem_r[rd_ptr_r];
      out_tag = tag_mem_r[rd_ptr_r];
`ifdef IMM_GEN_ILLEGAL_FLAG_EN
      out_illegal = ill_mem_r[rd_ptr_r];
`endif
    end else begin
      out_imm = {XLEN{1'b0}};
      out_fmt = 3'd0;
      out_tag = {TAG_W{1'b0}};
`ifdef IMM_GEN_ILLEGAL_FLAG_EN
      out_illegal = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_imm_gen_queue.sv
// Directed scoreboard bench for imm_gen_queue at XLEN=64, DEPTH=2.
module tb_imm_gen_queue;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [31:0] tag;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = 32'h0;
  logic [31:0] in_tag = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_imm;
  logic [2:0]  out_fmt;
  logic [31:0] out_tag;
`ifdef IMM_GEN_ILLEGAL_FLAG_EN
  logic        out_illegal;
`endif

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  logic acc;

  imm_gen_queue #(.XLEN(64), .DEPTH(2), .TAG_W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_fmt   (out_fmt),
`ifdef IMM_GEN_ILLEGAL_FLAG_EN
    .out_illegal (out_illegal),
`endif
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One cycle: drive inputs after a falling edge, compare state, update the
  // scoreboard with what the coming rising edge will do, then wait a cycle.
  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] tag,
                       input logic rdy, input logic fl, input logic [63:0] eimm,
                       input logic [2:0] efmt, input logic eill, output logic accepted);
    exp_t e;
    in_valid = v; in_inst = inst; in_tag = tag; out_ready = rdy; flush = fl;
    #1;
    check("out_valid", {63'd0, out_valid}, {63'd0, sb.size() != 0});
    check("in_ready", {63'd0, in_ready}, {63'd0, sb.size() < 2});
    if (out_valid && sb.size() != 0) begin
      check("out_imm", out_imm, sb[0].imm);
      check("out_fmt", {61'd0, out_fmt}, {61'd0, sb[0].fmt});
      check("out_tag", {32'd0, out_tag}, {32'd0, sb[0].tag});
`ifdef IMM_GEN_ILLEGAL_FLAG_EN
      check("out_illegal", {63'd0, out_illegal}, {63'd0, sb[0].ill});
`endif
    end
    accepted = v && (sb.size() < 2) && !fl;
    if (fl) begin
      sb.delete();
    end else begin
      if (out_valid && rdy && sb.size() != 0) void'(sb.pop_front());
      if (accepted) begin
        e.imm = eimm; e.fmt = efmt; e.tag = tag; e.ill = eill;
        sb.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, rdy, 1'b0, 64'h0, 3'd0, 1'b0, acc);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    #1;
    sb.delete();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_imm", out_imm, 64'd0);
    check("rst_out_fmt", {61'd0, out_fmt}, 64'd0);
    check("rst_out_tag", {32'd0, out_tag}, 64'd0);
`ifdef IMM_GEN_ILLEGAL_FLAG_EN
    check("rst_out_illegal", {63'd0, out_illegal}, 64'd0);
`endif
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int tries;
    @(negedge clk);
    apply_reset();
    check("ready_after_reset", {63'd0, in_ready}, 64'd1);

    // I, S, B, U, J directed vectors
    drive(1'b1, 32'hFFF00093, 32'h000000A0, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, acc);
    idle(1'b1, 1);
    drive(1'b1, 32'h0020A423, 32'h000000B0, 1'b1, 1'b0, 64'h0000000000000008, 3'd2, 1'b0, acc);
    drive(1'b1, 32'hFE000EE3, 32'h000000B1, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0, acc);
    drive(1'b1, 32'h80000037, 32'h000000C0, 1'b1, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0, acc);
    drive(1'b1, 32'h0080006F, 32'h000000C1, 1'b1, 1'b0, 64'h0000000000000008, 3'd5, 1'b0, acc);
    idle(1'b1, 2);

    // Backpressure: tag 3 must be held until space frees up
    drive(1'b1, 32'h00500093, 32'h1, 1'b0, 1'b0, 64'h5, 3'd1, 1'b0, acc);
    drive(1'b1, 32'h00600093, 32'h2, 1'b0, 1'b0, 64'h6, 3'd1, 1'b0, acc);
    drive(1'b1, 32'h00700093, 32'h3, 1'b0, 1'b0, 64'h7, 3'd1, 1'b0, acc);
    check("full_rejects_tag3", {63'd0, acc}, 64'd0);
    drive(1'b1, 32'h00700093, 32'h3, 1'b0, 1'b0, 64'h7, 3'd1, 1'b0, acc);
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 10) begin
      drive(1'b1, 32'h00700093, 32'h3, 1'b1, 1'b0, 64'h7, 3'd1, 1'b0, acc);
      tries++;
    end
    check("tag3_accepted", {63'd0, acc}, 64'd1);
    idle(1'b1, 3);

    // Flush with two entries buffered and a same-cycle push
    drive(1'b1, 32'h00100093, 32'h10, 1'b0, 1'b0, 64'h1, 3'd1, 1'b0, acc);
    drive(1'b1, 32'h00200093, 32'h11, 1'b0, 1'b0, 64'h2, 3'd1, 1'b0, acc);
    drive(1'b1, 32'h00300093, 32'h12, 1'b0, 1'b1, 64'h3, 3'd1, 1'b0, acc);
    #1;
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    idle(1'b1, 1);

    // Unknown opcode and a bad low-bit encoding
    drive(1'b1, 32'h0000007F, 32'h20, 1'b1, 1'b0, 64'h0, 3'd0, 1'b1, acc);
    drive(1'b1, 32'h00100090, 32'h21, 1'b1, 1'b0, 64'h0, 3'd0, 1'b1, acc);
    idle(1'b1, 2);

    // Reset mid-stream drops buffered entries
    drive(1'b1, 32'h00400093, 32'h30, 1'b0, 1'b0, 64'h4, 3'd1, 1'b0, acc);
    drive(1'b1, 32'hFFF00093, 32'h31, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, acc);
    apply_reset();
    idle(1'b1, 2);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
